// File: rtl/ep_trn_arb.sv
// Round-robin owner of the endpoint TRN tx port, shared by the rx and tx datapaths.
// Registered one-hot grants, an idle-grant timeout, and a zero-latency mux of the owner's TRN signals.
module ep_trn_arb #(
  parameter int GRANT_TO = 16,
  parameter int TO_W     = 5
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [63:0] rx_trn_td,
  input  logic [7:0]  rx_trn_trem_n,
  input  logic        rx_trn_tsof_n,
  input  logic        rx_trn_teof_n,
  input  logic        rx_trn_tsrc_rdy_n,
  input  logic        rx_drv_ep,
  output logic        rx_my_trn,

  input  logic [63:0] tx_trn_td,
  input  logic [7:0]  tx_trn_trem_n,
  input  logic        tx_trn_tsof_n,
  input  logic        tx_trn_teof_n,
  input  logic        tx_trn_tsrc_rdy_n,
  input  logic        tx_drv_ep,
  output logic        tx_my_trn,

  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        arb_err
);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic OWN_RX = 1'b0;
  localparam logic OWN_TX = 1'b1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(GRANT_TO - 1);

  state_t          state, state_nxt;
  logic            owner, owner_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;

  logic own_drv;
  logic oth_drv;
  logic fwd;
  logic viol;

  assign own_drv = (owner == OWN_TX) ? tx_drv_ep : rx_drv_ep;
  assign oth_drv = (owner == OWN_TX) ? rx_drv_ep : tx_drv_ep;

  // A requester that misbehaves is only flagged; it never steers the FSM.
  assign viol = oth_drv | ((state == GAP) & (rx_drv_ep | tx_drv_ep));

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    unique case (state)
      WAIT: begin
        if (own_drv) begin
          state_nxt = BUSY;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      BUSY: begin
        if (!own_drv) state_nxt = GAP;
      end
      GAP: begin
        state_nxt = WAIT;
        owner_nxt = ~owner;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Grants are derived from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT;
      owner     <= OWN_RX;
      cnt       <= '0;
      rx_my_trn <= 1'b1;
      tx_my_trn <= 1'b0;
      arb_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      cnt       <= cnt_nxt;
      rx_my_trn <= (state_nxt != GAP) && (owner_nxt == OWN_RX);
      tx_my_trn <= (state_nxt != GAP) && (owner_nxt == OWN_TX);
      arb_err   <= viol;
    end
  end

  assign fwd = own_drv & (state != GAP);

  always_comb begin
    trn_td         = 64'd0;
    trn_trem_n     = 8'hFF;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    if (fwd) begin
      if (owner == OWN_TX) begin
        trn_td         = tx_trn_td;
        trn_trem_n     = tx_trn_trem_n;
        trn_tsof_n     = tx_trn_tsof_n;
        trn_teof_n     = tx_trn_teof_n;
        trn_tsrc_rdy_n = tx_trn_tsrc_rdy_n;
      end else begin
        trn_td         = rx_trn_td;
        trn_trem_n     = rx_trn_trem_n;
        trn_tsof_n     = rx_trn_tsof_n;
        trn_teof_n     = rx_trn_teof_n;
        trn_tsrc_rdy_n = rx_trn_tsrc_rdy_n;
      end
    end
  end

endmodule

// File: doc/ep_trn_arb.md
Name: ep_trn_arb

Overview:
- Shares the PCIe endpoint TRN tx interface between the rx datapath (frame-to-TLP engine) and the tx datapath (descriptor/read-request engine).
- Issues a one-hot grant (my_trn) to one requester at a time and tracks ownership through each requester's drv_ep.
- Muxes the owner's TRN tx signals onto the endpoint and rotates ownership round-robin, with an idle-grant timeout.
- Sits between both requesters and the endpoint core, in the pcie_clk domain.

Parameters:
- GRANT_TO, 16, cycles a granted requester may hold a grant without asserting drv_ep before the grant rotates (legal range 2..2^TO_W-1).
- TO_W, 5, timeout counter width.

Ports:
- clk  in  1  pcie clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_trn_td  in  64  rx requester data
- rx_trn_trem_n  in  8  rx remainder
- rx_trn_tsof_n  in  1  rx start of frame
- rx_trn_teof_n  in  1  rx end of frame
- rx_trn_tsrc_rdy_n  in  1  rx source ready
- rx_drv_ep  in  1  rx is driving the endpoint
- rx_my_trn  out  1  grant to rx
- tx_trn_td  in  64  tx requester data
- tx_trn_trem_n  in  8  tx remainder
- tx_trn_tsof_n  in  1  tx start of frame
- tx_trn_teof_n  in  1  tx end of frame
- tx_trn_tsrc_rdy_n  in  1  tx source ready
- tx_drv_ep  in  1  tx is driving the endpoint
- tx_my_trn  out  1  grant to tx
- trn_td  out  64  to endpoint
- trn_trem_n  out  8  to endpoint
- trn_tsof_n  out  1  to endpoint
- trn_teof_n  out  1  to endpoint
- trn_tsrc_rdy_n  out  1  to endpoint
- arb_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset is asynchronous on rst_n low. Reset values: owner=RX, state=WAIT, timeout count=0, rx_my_trn=1, tx_my_trn=0, arb_err=0.
- Reset mid-transfer aborts ownership immediately. Requesters are reset by the same rst_n.
- State register holds one of WAIT, BUSY, GAP; the owner register is 1 bit.
- Grants are registered outputs:
  - In WAIT and BUSY, my_trn is 1 for the owner and 0 for the other requester.
  - In GAP, both grants are 0.
- WAIT:
  - Owner drv_ep=1 -> BUSY next cycle; count cleared.
  - Otherwise count increments; when count==GRANT_TO-1 -> GAP.
- BUSY:
  - Stay while owner drv_ep=1. No timeout applies in BUSY.
  - Owner drv_ep falling (sampled 0) -> GAP.
- GAP (exactly 1 cycle):
  - owner toggles; -> WAIT with count=0.
  - The new owner's my_trn rises on the cycle after GAP.
- Rotation is strict alternation regardless of request. An idle requester forfeits after GRANT_TO cycles, so worst-case grant latency is GRANT_TO+1 cycles.
- Mux (combinational, zero latency):
  - When the owner's drv_ep=1 and state is WAIT or BUSY, all trn_* outputs equal the owner's inputs.
  - Otherwise outputs are idle: td=0, trem_n=8'hFF, tsof_n=1, teof_n=1, tsrc_rdy_n=1.
  - The requester's drv_ep=1 in the same cycle as its my_trn forwards that cycle.
- Endpoint backpressure: trn_tdst_rdy_n and trn_tbuf_av go directly to both requesters and are not handled here. A requester must hold drv_ep high until its final beat is accepted.
- arb_err pulses for one cycle when any of these holds:
  - the non-owner asserts drv_ep;
  - any drv_ep is 1 during GAP.
- An offending requester's signals are never forwarded, and arb_err does not change state.
- Simultaneous events:
  - Owner drv_ep rising on the timeout cycle: BUSY wins and the timeout is ignored.
  - Both drv_ep high: the owner is served and arb_err pulses.

Test Plan:
- Reset, no activity -> rx_my_trn=1 for 16 cycles, then both grants 0 for 1 cycle, then tx_my_trn=1; outputs idle throughout (trn_tsrc_rdy_n=1, trn_trem_n=FF).
- rx asserts rx_drv_ep 3 cycles after reset for a 5-beat TLP (td=0xA0..A4) -> trn_td shows A0..A4 in the same cycles; after rx_drv_ep falls, 1-cycle GAP, then tx_my_trn=1.
- Back-to-back: both requesters always drive drv_ep for 4 beats on grant -> grants alternate RX,TX,RX with exactly one GAP cycle between each; no arb_err.
- tx asserts tx_drv_ep while rx owns -> arb_err one-cycle pulse; trn_* remain rx/idle values; rotation timing unchanged.
- rx raises drv_ep on cycle count==15 -> state BUSY, no rotation; rx holds 40 cycles -> still owner (no timeout in BUSY).
- rst_n low mid-BUSY owned by tx -> asynchronously rx_my_trn=1, tx_my_trn=0, outputs idle; after release, WAIT with count 0.
